// File: rtl/process_data_mul_pipe_acc_if.sv
// Sample/result bus of process_data_mul_pipe_acc: operands, flags and clock enable in,
// saturated result with valid and clip flag out.
interface process_data_mul_pipe_acc_if #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 26
);
  logic                         ce;
  logic                         in_valid;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         acc_clr;
  logic                         acc_last;
  logic                         out_valid;
  logic signed [dout_WIDTH-1:0] dout;
  logic                         sat_flag;

  modport master (
    output ce, in_valid, din0, din1, acc_clr, acc_last,
    input  out_valid, dout, sat_flag
  );

  modport slave (
    input  ce, in_valid, din0, din1, acc_clr, acc_last,
    output out_valid, dout, sat_flag
  );
endinterface

// File: rtl/process_data_mul_pipe_acc.sv
// Pipelined signed multiplier with saturating narrowing to dout_WIDTH.
// Define PROCESS_DATA_MUL_ACC_EN to add the grouped multiply-accumulate mode.
module process_data_mul_pipe_acc #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 26,
  parameter int ACC_WIDTH  = 40
) (
  input logic                      clk,
  input logic                      reset,
  process_data_mul_pipe_acc_if.slave bus
);
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int D  = NUM_STAGE - 2;

`ifdef PROCESS_DATA_MUL_ACC_EN
  // Flag vector layout: [0] valid, [1] clr, [2] last.
  localparam int FW = 3;
  localparam int SW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;
`else
  localparam int FW = 1;
  localparam int SW = PW;
`endif

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};
  localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  logic [FW-1:0] f_in;
`ifdef PROCESS_DATA_MUL_ACC_EN
  assign f_in = {bus.acc_last, bus.acc_clr, bus.in_valid};
`else
  assign f_in = bus.in_valid;
`endif

  // Stage 1: operand and flag capture.
  logic signed [din0_WIDTH-1:0] a_q;
  logic signed [din1_WIDTH-1:0] b_q;
  logic [FW-1:0]                f_q;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge value of its source, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
    end else if (bus.ce) begin
      a_q <= bus.din0;
      b_q <= bus.din1;
      f_q <= f_in;
    end
  end

  // Sign-extending casts keep the full-width product exact.
  logic signed [PW-1:0] prod;
  assign prod = PW'(a_q) * PW'(b_q);

  logic signed [PW-1:0] fin_p;
  logic [FW-1:0]        fin_f;

  if (D == 0) begin : g_nopipe
    assign fin_p = prod;
    assign fin_f = f_q;
  end else begin : g_pipe
    logic signed [PW-1:0] p_q  [D];
    logic [FW-1:0]        pf_q [D];

    // NOTE: the product delay line is reset element by element so no stale sample
    // survives a mid-operation reset; it is small enough to keep in flops.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < D; i++) begin
          p_q[i]  <= '0;
          pf_q[i] <= '0;
        end
      end else if (bus.ce) begin
        p_q[0]  <= prod;
        pf_q[0] <= f_q;
        for (int i = 1; i < D; i++) begin
          p_q[i]  <= p_q[i-1];
          pf_q[i] <= pf_q[i-1];
        end
      end
    end

    assign fin_p = p_q[D-1];
    assign fin_f = pf_q[D-1];
  end

  logic signed [SW-1:0] sat_in;
`ifdef PROCESS_DATA_MUL_ACC_EN
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_next;
  assign acc_next = (fin_f[1] ? '0 : acc_q) + ACC_WIDTH'(fin_p);
  assign sat_in   = SW'(acc_next);
`else
  assign sat_in   = SW'(fin_p);
`endif

  logic                  sat_hi;
  logic                  sat_lo;
  logic [dout_WIDTH-1:0] sat_val;
  assign sat_hi  = sat_in > SAT_MAX;
  assign sat_lo  = sat_in < SAT_MIN;
  assign sat_val = sat_hi ? DOUT_MAX : (sat_lo ? DOUT_MIN : sat_in[dout_WIDTH-1:0]);

  // Final stage: output register (and accumulator).
  logic                  ov_q;
  logic [dout_WIDTH-1:0] dout_q;
  logic                  sat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_q   <= 1'b0;
      dout_q <= '0;
      sat_q  <= 1'b0;
`ifdef PROCESS_DATA_MUL_ACC_EN
      acc_q  <= '0;
`endif
    end else if (bus.ce) begin
`ifdef PROCESS_DATA_MUL_ACC_EN
      ov_q <= fin_f[0] & fin_f[2];
      if (fin_f[0]) begin
        acc_q <= acc_next;
        if (fin_f[2]) begin
          dout_q <= sat_val;
          sat_q  <= sat_hi | sat_lo;
        end
      end
`else
      ov_q <= fin_f[0];
      if (fin_f[0]) begin
        dout_q <= sat_val;
        sat_q  <= sat_hi | sat_lo;
      end
`endif
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.dout      = dout_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_process_data_mul_pipe_acc.sv
// Self-checking bench for process_data_mul_pipe_acc: directed vector table, stall,
// reset and accumulate sequences, then randomized traffic against a queue model.
module tb_process_data_mul_pipe_acc;
  localparam int NS = 3;
  localparam int W  = 26;
`ifdef PROCESS_DATA_MUL_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  localparam longint SMAX = (64'sd1 <<< (W-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W-1));

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  process_data_mul_pipe_acc_if bus ();

  process_data_mul_pipe_acc #(.NUM_STAGE(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: results computed at acceptance, released NS-1 ce-edges later.
  typedef struct {int due; longint val; bit sat;} res_t;
  res_t   q[$];
  int     n = 0;
  longint acc_m = 0;
  bit     exp_ov = 0;
  longint exp_dout = 0;
  bit     exp_sat = 0;

  function automatic longint sat_fn(input longint x);
    return (x > SMAX) ? SMAX : ((x < SMIN) ? SMIN : x);
  endfunction

  task automatic push(input longint x);
    res_t r;
    r.due = n + NS - 1;
    r.val = sat_fn(x);
    r.sat = (x > SMAX) || (x < SMIN);
    q.push_back(r);
  endtask

  task automatic model_accept();
    longint p;
    p = longint'(bus.din0) * longint'(bus.din1);
    if (!ACC) push(p);
    else begin
      acc_m = (bus.acc_clr ? 64'sd0 : acc_m) + p;
      acc_m = (acc_m <<< 24) >>> 24;  // wrap to 40 bits
      if (bus.acc_last) push(acc_m);
    end
  endtask

  task automatic model_clear();
    q.delete();
    acc_m = 0; exp_ov = 0; exp_dout = 0; exp_sat = 0;
  endtask

  task automatic step();
    bit cur_ce;
    cur_ce = bus.ce && !reset;
    if (cur_ce) begin
      n++;
      if (bus.in_valid) model_accept();
    end
    @(posedge clk);
    #1;
    if (reset) model_clear();
    else if (cur_ce) begin
      if (q.size() > 0 && q[0].due == n) begin
        exp_ov = 1; exp_dout = q[0].val; exp_sat = q[0].sat;
        void'(q.pop_front());
      end else exp_ov = 0;
    end
    check("out_valid", bus.out_valid, exp_ov);
    check("dout", bus.dout, exp_dout);
    check("sat_flag", bus.sat_flag, exp_sat);
  endtask

  task automatic send(input int a, input int b, input bit clr, input bit last);
    bus.ce = 1; bus.in_valid = 1;
    bus.din0 = 16'(a); bus.din1 = 16'(b);
    bus.acc_clr = clr; bus.acc_last = last;
    step();
    bus.in_valid = 0; bus.acc_clr = 0; bus.acc_last = 0;
  endtask

  task automatic wait_result(input string name, input longint exp, input bit sat);
    bus.ce = 1; bus.in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) begin
        check({name, "_dout"}, bus.dout, exp);
        check({name, "_sat"}, bus.sat_flag, sat);
        return;
      end
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {int a; int b; longint exp; bit sat;} vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{100, -3, -300, 1'b0};
    tbl[1] = '{32767, 32767, 33554431, 1'b1};
    tbl[2] = '{-32768, 32767, -33554432, 1'b1};
    tbl[3] = '{-32768, -32768, 33554431, 1'b1};
    tbl[4] = '{18631, 1801, 33554431, 1'b0};
    tbl[5] = '{-32768, 1024, -33554432, 1'b0};
    tbl[6] = '{-32768, -1024, 33554431, 1'b1};
    tbl[7] = '{-7, 9, -63, 1'b0};

    reset = 1;
    bus.ce = 0; bus.in_valid = 0; bus.din0 = 0; bus.din1 = 0;
    bus.acc_clr = 0; bus.acc_last = 0;
    step();
    step();
    reset = 0;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, 1'b1, 1'b1);
      wait_result($sformatf("vec%0d", i), tbl[i].exp, tbl[i].sat);
    end

    // Stall between two samples; garbage while ce=0 must be ignored.
    send(2, 3, 1'b1, 1'b1);
    bus.ce = 0; bus.in_valid = 1; bus.din0 = 999; bus.din1 = -999;
    bus.acc_clr = 1; bus.acc_last = 1;
    step();
    step();
    send(4, 5, 1'b1, 1'b1);
    wait_result("stall_a", 6, 1'b0);
    wait_result("stall_b", 20, 1'b0);

`ifdef PROCESS_DATA_MUL_ACC_EN
    send(10, 20, 1'b1, 1'b0);
    send(-5, 4, 1'b0, 1'b0);
    send(3, 3, 1'b0, 1'b1);
    wait_result("acc_group", 189, 1'b0);
    send(7, 7, 1'b1, 1'b1);
    wait_result("acc_single", 49, 1'b0);
`endif

    // Reset with two samples in flight.
    send(11, 12, 1'b1, 1'b1);
    send(13, 14, 1'b1, 1'b1);
    reset = 1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_sat", bus.sat_flag, 0);
    model_clear();
    step();
    reset = 0;
    bus.ce = 1;
    for (int i = 0; i < 4; i++) step();
    send(1, 1, 1'b1, 1'b1);
    wait_result("rst_first", 1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      bus.ce = ($urandom_range(0, 4) != 0);
      bus.in_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: begin bus.din0 = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
                 bus.din1 = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000; end
        1: begin bus.din0 = 16'($urandom_range(0, 255) - 128);
                 bus.din1 = 16'($urandom_range(0, 255) - 128); end
        default: begin bus.din0 = 16'($urandom); bus.din1 = 16'($urandom); end
      endcase
      bus.acc_clr = ($urandom_range(0, 3) == 0);
      bus.acc_last = ($urandom_range(0, 2) == 0);
      step();
    end
    bus.ce = 1; bus.in_valid = 0;
    for (int i = 0; i < 6; i++) step();
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/process_data_mul_pipe_acc.md
# process_data_mul_pipe_acc

Pipelined signed multiplier with valid tracking, clock enable, saturating narrowing to the output width and an optional multiply-accumulate mode. It is the parametrised successor to the single-cycle combinational signed multipliers in the `process_data` datapath. It is used where the product must be registered to meet timing, clipped to a narrower result, or summed over a sample group such as a dot product over ADC channels.

## Interface
Parameters:
- `ID`, 1, instance tag only; no functional effect.
- `NUM_STAGE`, 3, total latency in `ce`-enabled cycles; legal range 2..6.
- `din0_WIDTH`, 16, signed width of operand A.
- `din1_WIDTH`, 16, signed width of operand B.
- `dout_WIDTH`, 26, signed result width; must be ≤ din0_WIDTH+din1_WIDTH.
- `ACC_WIDTH`, 40, accumulator width; must be ≥ din0_WIDTH+din1_WIDTH. Used only when the accumulate feature is compiled in.

Ports:
- `clk` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ce` in 1: pipeline advance enable; 0 freezes every register.
- `in_valid` in 1: din0/din1 (and flags) hold a sample.
- `din0` in din0_WIDTH: signed operand A.
- `din1` in din1_WIDTH: signed operand B.
- `acc_clr` in 1: sample starts a new accumulation (accumulate build only; ignored otherwise).
- `acc_last` in 1: sample ends the accumulation (accumulate build only; ignored otherwise).
- `out_valid` out 1: dout/sat_flag are valid this cycle.
- `dout` out dout_WIDTH: signed, saturated result.
- `sat_flag` out 1: dout was clipped.

## Operation
- Stage 1 registers din0, din1, in_valid, acc_clr and acc_last.
- Stages 2..NUM_STAGE-1 carry the full-precision product P = din0·din1 (din0_WIDTH+din1_WIDTH bits, exact). The multiply may be split across these stages, but it must be bit-exact.
- Stage NUM_STAGE is the output register, and the accumulator when that feature is compiled in.
- The valid bit and flags travel in a shift register alongside the data. A sample with in_valid=0 is a bubble and produces no out_valid.
- Saturation rule SAT(x):
  - if x > 2^(dout_WIDTH-1)-1 → max, sat_flag=1;
  - if x < -2^(dout_WIDTH-1) → min, sat_flag=1;
  - else x, sat_flag=0.
- Without accumulate: for each valid sample, the final stage loads dout=SAT(P) and asserts out_valid for one ce-cycle.
- With accumulate, on each valid sample at the final stage:
  - acc_next = (clr ? 0 : acc) + sign-extended P.
  - The add wraps modulo 2^ACC_WIDTH; overflow is not detected.
  - acc is updated to acc_next.
  - If last=1: dout=SAT(acc_next) and out_valid=1. Otherwise out_valid=0 and dout holds its previous value.
  - clr and last on the same sample give a one-term result, dout=SAT(P).
  - A sample with clr=0 after a completed group continues summing from the previous acc.
- A bubble leaves acc unchanged.

## Timing
- Latency: a sample accepted with in_valid=1 at ce-cycle k appears at ce-cycle k+NUM_STAGE.
- Throughput: one sample per ce-cycle; there is no back-pressure.
- out_valid is a single-cycle pulse per result while ce=1. While ce=0, all outputs hold, including out_valid, which must be qualified with ce by the consumer.
- Reset values: all pipeline registers, valid/flag shift registers, acc, dout, out_valid and sat_flag are 0.
- Reset mid-operation discards in-flight samples and the partial accumulation. The first output after reset release is produced by the first sample accepted after release.
- in_valid, din0, din1 and the flags are ignored while ce=0.

## Configuration
- `PROCESS_DATA_MUL_ACC_EN` defined: the accumulator, acc_clr and acc_last are active, and out_valid marks only group-final samples.
- `PROCESS_DATA_MUL_ACC_EN` undefined: pure pipelined saturating multiplier. acc_clr and acc_last remain as ports but are unused, and no accumulator register is instantiated.

## Test plan
All cases use default parameters (NUM_STAGE=3, 16×16 operands, 26-bit dout).
- Basic product: din0=100, din1=-3, in_valid=1 for one cycle → out_valid exactly 3 cycles later, dout=-300, sat_flag=0.
- Saturation:
  - 32767·32767 → dout=33554431, sat_flag=1.
  - -32768·32767 → dout=-33554432, sat_flag=1.
  - -32768·-32768 → dout=33554431, sat_flag=1.
- Stall: back-to-back samples (2,3),(4,5) with ce held low for 2 cycles between them → results 6 and 20 arrive in order, each after 3 ce-high cycles. Outputs are frozen during the stall.
- Accumulate (macro on): (10,20,clr), (-5,4), (3,3,last) → one out_valid, dout=189. The next group, (7,7,clr+last), gives dout=49.
- Reset: reset asserted while 2 samples are in flight → out_valid, dout and sat_flag are 0 immediately. No stale output appears after release, and the first new sample (1,1) yields dout=1 three cycles after acceptance.
